des_key_sched_iter: RTL and testbench

- Iterative DES round-key generator: loads one 64-bit key, then streams the 16 48-bit subkeys one per handshake.
- Order is selectable: encrypt order K1..K16 (left rotations) or decrypt order K16..K1 (right rotations).
- Sits between the key register and the iterative DES round datapath; replaces a flat 16-subkey array with one C/D register pair.

---
 rtl/des_key_sched_iter.sv | 214 +++++++++++++++++++++
 tb/tb_des_key_sched_iter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_iter.sv
// des_key_sched_iter
//   Iterative DES round-key generator. One 64-bit key is loaded through a
//   valid/ready offer; the 16 48-bit subkeys are then streamed one per
//   sk_valid/sk_ready handshake, in encrypt order (K1..K16, left rotations)
//   or decrypt order (K16..K1, right rotations). A single C/D register pair
//   replaces a flat 16-entry subkey array.
//
// Parameters
//   SCRUB_IDLE : 1 = sk_out forced to zero while sk_valid is low,
//                0 = sk_out holds the last subkey presented.
//
// Optional build macro
//   DES_KEY_PARITY_CHECK_EN : adds output parity_err. A key with any byte of
//   even parity is accepted but produces no subkeys; parity_err stays high
//   until the next accepted load or reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   key_in     in   [63:0] DES key, key_in[63] = DES bit 1, key_in[0] = DES bit 64
//   decrypt    in   sampled at load: 1 = K16..K1, 0 = K1..K16
//   load_valid in   key offer
//   load_ready out  high only while idle
//   sk_out     out  [47:0] current subkey, sk_out[47] = PC-2 output bit 1
//   sk_idx     out  [3:0] round number minus one of sk_out
//   sk_valid   out  sk_out/sk_idx valid
//   sk_ready   in   consumer accepts the subkey
//   done       out  one-cycle pulse after the 16th subkey handshake
//   parity_err out  (DES_KEY_PARITY_CHECK_EN only) last loaded key had bad parity

module des_key_sched_iter #(
  parameter bit SCRUB_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [47:0] sk_out,
  output logic [3:0]  sk_idx,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // PC-1: DES key bit number feeding C/D bits 1..56.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: C/D bit number feeding subkey bits 1..48.
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit (r-1) set when round r shifts by two; rounds 1, 2, 9 and 16 shift by one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  // C/D bit n (1-based) lives at cd[56-n]; C = cd[55:28], D = cd[27:0].
  function automatic logic [55:0] pc1_fn(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [47:0] last_sk_q, last_sk_d;

  logic [55:0] cd_load;
  logic [47:0] sk_cur;
  logic [3:0]  enc_shift_idx;
  logic [3:0]  dec_shift_idx;
  logic        key_ok;

  assign cd_load = pc1_fn(key_in);
  assign sk_cur  = pc2_fn(cd_q);

  // Encrypt prepares round cnt+2 (table index cnt+1); decrypt undoes the
  // round just emitted, 16-cnt (table index 15-cnt).
  assign enc_shift_idx = cnt_q + 4'd1;
  assign dec_shift_idx = ~cnt_q;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  function automatic logic odd_parity_all(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int unsigned b = 0; b < 8; b++) ok = ok & (^k[8*b +: 8]);
    return ok;
  endfunction

  assign key_ok     = odd_parity_all(key_in);
  assign parity_err = parity_err_q;
`else
  // Parity bits are discarded by PC-1 when the check is not built in.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign key_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    done_d    = 1'b0;
    last_sk_d = last_sk_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          dec_d = decrypt;
          cnt_d = '0;
          // C0D0 is already C16D16 for decrypt; encrypt starts at C1D1.
          cd_d  = decrypt ? cd_load
                          : {rotl(cd_load[55:28], 1'b0), rotl(cd_load[27:0], 1'b0)};
`ifdef DES_KEY_PARITY_CHECK_EN
          parity_err_d = ~key_ok;
`endif
          state_d = key_ok ? RUN : IDLE;
        end
      end
      RUN: begin
        last_sk_d = sk_cur;
        if (sk_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (dec_q) begin
            cd_d = {rotr(cd_q[55:28], SHIFT2[dec_shift_idx]),
                    rotr(cd_q[27:0],  SHIFT2[dec_shift_idx])};
          end else begin
            cd_d = {rotl(cd_q[55:28], SHIFT2[enc_shift_idx]),
                    rotl(cd_q[27:0],  SHIFT2[enc_shift_idx])};
          end
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      cnt_q     <= '0;
      dec_q     <= 1'b0;
      done_q    <= 1'b0;
      last_sk_q <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      done_q    <= done_d;
      last_sk_q <= last_sk_d;
`ifdef DES_KEY_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign load_ready = (state_q == IDLE);
  assign sk_valid   = (state_q == RUN);
  assign sk_out     = (state_q == RUN) ? sk_cur : (SCRUB_IDLE ? '0 : last_sk_q);
  assign sk_idx     = (state_q == RUN) ? (dec_q ? ~cnt_q : cnt_q) : '0;
  assign done       = done_q;

endmodule

// File: tb/tb_des_key_sched_iter.sv
module tb_des_key_sched_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        load_valid;
  logic        load_ready;
  logic [47:0] sk_out;
  logic [3:0]  sk_idx;
  logic        sk_valid;
  logic        sk_ready;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parity_err;
`endif

  des_key_sched_iter #(.SCRUB_IDLE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sk_out     (sk_out),
    .sk_idx     (sk_idx),
    .sk_valid   (sk_valid),
    .sk_ready   (sk_ready),
    .done       (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  // Published subkeys K1..K16 for KEY.
  logic [47:0] GOLD [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned hs_count = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake the consumer is about to take is checked.
  always @(negedge clk) begin
    if (rst === 1'b0 && sk_valid === 1'b1 && sk_ready === 1'b1) begin
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got sk=%h idx=%0d, required no subkey", sk_out, sk_idx);
      end else begin
        e = sb_q.pop_front();
        if (sk_out !== e.sk || sk_idx !== e.idx) begin
          n_err++;
          $display("FAIL sb_subkey: got sk=%h idx=%0d, required sk=%h idx=%0d",
                   sk_out, sk_idx, e.sk, e.idx);
        end
      end
      hs_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic dec);
    for (int i = 0; i < 16; i++) begin
      if (dec) sb_q.push_back({GOLD[15-i], 4'(15-i)});
      else     sb_q.push_back({GOLD[i], 4'(i)});
    end
  endtask

  task automatic wait_hs(input int unsigned target);
    int unsigned b = 0;
    while (hs_count < target && b < 200) begin
      tick();
      b++;
    end
    if (hs_count < target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_hs_timeout: got %0d handshakes, required %0d", hs_count, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = '0; decrypt = 1'b0; load_valid = 1'b0; sk_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rst_load_ready: got %b required 1", load_ready); end
    n_vec++; if (sk_valid !== 1'b0) begin n_err++; $display("FAIL rst_sk_valid: got %b required 0", sk_valid); end
    n_vec++; if (sk_idx !== 4'd0) begin n_err++; $display("FAIL rst_sk_idx: got %0d required 0", sk_idx); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    n_vec++; if (sk_out !== 48'h0) begin n_err++; $display("FAIL rst_sk_out: got %h required 0", sk_out); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_order(input logic dec);
    int unsigned hs0 = hs_count;
    sk_ready = 1'b1;
    key_in = KEY; decrypt = dec; load_valid = 1'b1;
    push_stream(dec);
    tick();
    load_valid = 1'b0;
    decrypt = ~dec;
    @(negedge clk);
    n_vec++;
    if (sk_valid !== 1'b1 || sk_out !== GOLD[dec ? 15 : 0] || sk_idx !== (dec ? 4'd15 : 4'd0)) begin
      n_err++;
      $display("FAIL first_subkey dec=%b: got v=%b sk=%h idx=%0d, required v=1 sk=%h idx=%0d",
               dec, sk_valid, sk_out, sk_idx, GOLD[dec ? 15 : 0], dec ? 15 : 0);
    end
    wait_hs(hs0 + 16);
    n_vec++;
    if (done !== 1'b1 || load_ready !== 1'b1 || sk_valid !== 1'b0 || sk_out !== 48'h0) begin
      n_err++;
      $display("FAIL end_of_stream dec=%b: got done=%b rdy=%b v=%b sk=%h, required 1 1 0 0",
               dec, done, load_ready, sk_valid, sk_out);
    end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_width dec=%b: got %b required 0", dec, done); end
  endtask

  task automatic test_backpressure();
    int unsigned hs0 = hs_count;
    sk_ready = 1'b1;
    key_in = KEY; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    wait_hs(hs0 + 3);
    sk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (sk_valid !== 1'b1 || sk_out !== GOLD[3] || sk_idx !== 4'd3) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: got v=%b sk=%h idx=%0d, required v=1 sk=%h idx=3",
                 i, sk_valid, sk_out, sk_idx, GOLD[3]);
      end
      tick();
    end
    sk_ready = 1'b1;
    wait_hs(hs0 + 16);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b required 1", done); end
    tick();
  endtask

  task automatic test_load_during_run();
    int unsigned hs0 = hs_count;
    sk_ready = 1'b1;
    key_in = KEY; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    wait_hs(hs0 + 5);
    key_in = 64'h0; decrypt = 1'b1; load_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL run_load_ready: got %b required 0", load_ready); end
    tick();
    tick();
    load_valid = 1'b0;
    wait_hs(hs0 + 16);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL run_load_done: got %b required 1", done); end
    tick();
    n_vec++; if (sk_valid !== 1'b0) begin n_err++; $display("FAIL run_load_queued: got sk_valid=%b required 0", sk_valid); end
  endtask

  task automatic test_reset_midstream();
    int unsigned hs0 = hs_count;
    logic saw_done = 1'b0;
    sk_ready = 1'b1;
    key_in = KEY; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    wait_hs(hs0 + 7);
    rst = 1'b1;
    #1;
    n_vec++;
    if (sk_valid !== 1'b0 || sk_out !== 48'h0 || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b sk=%h rdy=%b, required v=0 sk=0 rdy=1", sk_valid, sk_out, load_ready);
    end
    sb_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || sk_valid !== 1'b0) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_quiet: got activity=1 required 0"); end
    tick();
    hs0 = hs_count;
    key_in = KEY; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (sk_out !== GOLD[0] || sk_idx !== 4'd0) begin
      n_err++;
      $display("FAIL restart_k1: got sk=%h idx=%0d, required sk=%h idx=0", sk_out, sk_idx, GOLD[0]);
    end
    wait_hs(hs0 + 16);
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned hs0 = hs_count;
    int unsigned c1, c2;
    sk_ready = 1'b1;
    key_in = KEY; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    c1 = cyc;
    load_valid = 1'b0;
    wait_hs(hs0 + 16);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b required 1", done); end
    decrypt = 1'b1; load_valid = 1'b1;
    push_stream(1'b1);
    tick();
    c2 = cyc;
    load_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (sk_valid !== 1'b1 || sk_out !== GOLD[15] || sk_idx !== 4'd15) begin
      n_err++;
      $display("FAIL b2b_first: got v=%b sk=%h idx=%0d, required v=1 sk=%h idx=15",
               sk_valid, sk_out, sk_idx, GOLD[15]);
    end
    n_vec++; if (c2 - c1 != 17) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles required 17", c2 - c1); end
    wait_hs(hs0 + 32);
    tick();
  endtask

`ifdef DES_KEY_PARITY_CHECK_EN
  task automatic test_parity();
    int unsigned hs0 = hs_count;
    sk_ready = 1'b1;
    key_in = KEY_BAD; decrypt = 1'b0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (parity_err !== 1'b1 || sk_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL parity_bad: got perr=%b v=%b rdy=%b, required 1 0 1", parity_err, sk_valid, load_ready);
    end
    repeat (3) tick();
    n_vec++; if (sk_valid !== 1'b0 || parity_err !== 1'b1) begin n_err++; $display("FAIL parity_hold: got v=%b perr=%b required 0 1", sk_valid, parity_err); end
    key_in = KEY; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (parity_err !== 1'b0 || sk_valid !== 1'b1) begin n_err++; $display("FAIL parity_clear: got perr=%b v=%b required 0 1", parity_err, sk_valid); end
    wait_hs(hs0 + 16);
    tick();
  endtask
`else
  task automatic test_parity();
    int unsigned hs0 = hs_count;
    sk_ready = 1'b1;
    key_in = KEY_BAD; decrypt = 1'b0; load_valid = 1'b1;
    push_stream(1'b0);
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (sk_valid !== 1'b1 || sk_out !== GOLD[0]) begin n_err++; $display("FAIL parity_ignored: got v=%b sk=%h required v=1 sk=%h", sk_valid, sk_out, GOLD[0]); end
    wait_hs(hs0 + 16);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_backpressure();
    test_load_during_run();
    test_reset_midstream();
    test_back_to_back();
    test_parity();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending subkeys required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
